// File: rtl/i_merge_n_pkg.sv
// i_merge_n_pkg: shared MIC constants, merge FSM state type and index-width helper.
//   MIC_ROUTE_LSB / MIC_ROUTE_W : location of the route field in a header beat
//   MIC_DATA_W                  : default TDATA width of a MIC stream
package i_merge_n_pkg;

  localparam int unsigned MIC_ROUTE_LSB = 56;
  localparam int unsigned MIC_ROUTE_W   = 4;
  localparam int unsigned MIC_DATA_W    = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } merge_state_t;

  // Width of an index into n items; at least one bit so single-input builds still have a grant register.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i_merge_n_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     : request vector, one bit per requester
//   last    : index granted most recently; search starts at last+1 and wraps
//   gnt_idx : first requesting index found (holds last when nothing requests)
//   any     : at least one request is present
module rr_arbiter
  import i_merge_n_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int unsigned idx;

  // Walk from the farthest candidate to the nearest so the nearest requester overwrites the others.
  always_comb begin
    gnt_idx = last;
    any     = |req;
    idx     = 0;
    for (int unsigned off = N; off >= 1; off--) begin
      idx = (32'(last) + off) % N;
      if (req[IW'(idx)]) begin
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/i_merge_n.sv
// i_merge_n: N-input AXI-Stream packet merge, round-robin at packet granularity.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   I_TVALID/I_TREADY   : per-input beat handshake (I_TREADY is combinational)
//   I_TDATA             : input i at [i*DATA_W +: DATA_W]
//   I_TLAST             : per-input last beat of packet
//   O_TVALID/O_TDATA/O_TLAST : registered merged stream, held stable while stalled
//   O_TREADY            : downstream ready
// With PROD_ROUTE set, the header beat's route field is overwritten with the winning input index.
module i_merge_n
  import i_merge_n_pkg::*;
#(
  parameter int unsigned N_INPUTS   = 4,
  parameter int unsigned DATA_W     = MIC_DATA_W,
  parameter int unsigned PROD_ROUTE = 0,
  parameter int unsigned ROUTE_LSB  = MIC_ROUTE_LSB,
  parameter int unsigned ROUTE_W    = MIC_ROUTE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS-1:0]          I_TVALID,
  output logic [N_INPUTS-1:0]          I_TREADY,
  input  logic [N_INPUTS*DATA_W-1:0]   I_TDATA,
  input  logic [N_INPUTS-1:0]          I_TLAST,
  output logic                         O_TVALID,
  input  logic                         O_TREADY,
  output logic [DATA_W-1:0]            O_TDATA,
  output logic                         O_TLAST
);

  localparam int unsigned IW = idx_w(N_INPUTS);

  // Elaboration-time parameter checks.
  if (N_INPUTS < 1 || N_INPUTS > 16) begin : g_bad_n
    $error("i_merge_n: N_INPUTS must be in 1..16");
  end
  if (ROUTE_W < $clog2(N_INPUTS)) begin : g_bad_route_w
    $error("i_merge_n: ROUTE_W too narrow for N_INPUTS");
  end
  if (PROD_ROUTE != 0 && ROUTE_LSB + ROUTE_W > DATA_W) begin : g_bad_route_lsb
    $error("i_merge_n: route field outside DATA_W");
  end

  merge_state_t       state, state_d;
  logic [IW-1:0]      grant, grant_d;
  logic [IW-1:0]      last_grant, last_grant_d;
  logic               hdr, hdr_d;
  logic               o_valid_d, o_last_d;
  logic [DATA_W-1:0]  o_data_d;

  logic [IW-1:0]      arb_idx_c;
  logic               arb_any_c;
  logic               out_free_c;
  logic               accept_c;
  logic [DATA_W-1:0]  sel_data_c;
  logic [DATA_W-1:0]  beat_data_c;

  // Next-packet pick, rotating from the input after the last one served.
  rr_arbiter #(.N(N_INPUTS)) u_arb (
    .req     (I_TVALID),
    .last    (last_grant),
    .gnt_idx (arb_idx_c),
    .any     (arb_any_c)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign out_free_c = !O_TVALID || O_TREADY;
  assign sel_data_c = I_TDATA[32'(grant)*DATA_W +: DATA_W];

  // Route stamp applies to the header beat only.
  if (PROD_ROUTE != 0) begin : g_stamp
    always_comb begin
      beat_data_c = sel_data_c;
      if (hdr) begin
        beat_data_c[ROUTE_LSB +: ROUTE_W] = ROUTE_W'(grant);
      end
    end
  end else begin : g_pass
    assign beat_data_c = sel_data_c;
  end

  // Next-state, ready and output-register load.
  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    hdr_d        = hdr;
    o_valid_d    = O_TVALID;
    o_data_d     = O_TDATA;
    o_last_d     = O_TLAST;
    I_TREADY     = '0;
    accept_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arb_any_c) begin
          grant_d = arb_idx_c;
          hdr_d   = 1'b1;
          state_d = ST_PKT;
        end
      end
      ST_PKT: begin
        I_TREADY[grant] = out_free_c;
        accept_c        = I_TVALID[grant] && out_free_c;
        if (accept_c) begin
          hdr_d = 1'b0;
          if (I_TLAST[grant]) begin
            last_grant_d = grant;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      o_valid_d = 1'b1;
      o_data_d  = beat_data_c;
      o_last_d  = I_TLAST[grant];
    end else if (O_TREADY) begin
      o_valid_d = 1'b0;
    end
  end

  // State and output registers; last_grant resets so input 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IW'(N_INPUTS - 1);
      hdr        <= 1'b0;
      O_TVALID   <= 1'b0;
      O_TDATA    <= '0;
      O_TLAST    <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      hdr        <= hdr_d;
      O_TVALID   <= o_valid_d;
      O_TDATA    <= o_data_d;
      O_TLAST    <= o_last_d;
    end
  end

endmodule

// File: tb/tb_i_merge_n.sv
// tb_i_merge_n: directed and randomized checks of a 4-input stamping merge and a 1-input passthrough merge.
module tb_i_merge_n;

  localparam int unsigned NA = 4;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [NA-1:0]    a_ivalid, a_iready, a_ilast;
  logic [NA*DW-1:0] a_idata;
  logic             a_ovalid, a_oready, a_olast;
  logic [DW-1:0]    a_odata;

  logic [0:0]       b_ivalid, b_iready, b_ilast;
  logic [DW-1:0]    b_idata;
  logic             b_ovalid, b_oready, b_olast;
  logic [DW-1:0]    b_odata;

  int vectors = 0;
  int miscompares = 0;

  i_merge_n #(.N_INPUTS(NA), .DATA_W(DW), .PROD_ROUTE(1), .ROUTE_LSB(56), .ROUTE_W(4)) u_dut_a (
    .clk(clk), .reset(rst),
    .I_TVALID(a_ivalid), .I_TREADY(a_iready), .I_TDATA(a_idata), .I_TLAST(a_ilast),
    .O_TVALID(a_ovalid), .O_TREADY(a_oready), .O_TDATA(a_odata), .O_TLAST(a_olast)
  );

  i_merge_n #(.N_INPUTS(1), .DATA_W(DW), .PROD_ROUTE(0), .ROUTE_LSB(56), .ROUTE_W(4)) u_dut_b (
    .clk(clk), .reset(rst),
    .I_TVALID(b_ivalid), .I_TREADY(b_iready), .I_TDATA(b_idata), .I_TLAST(b_ilast),
    .O_TVALID(b_ovalid), .O_TREADY(b_oready), .O_TDATA(b_odata), .O_TLAST(b_olast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Header with the source index written into the route field.
  function automatic logic [63:0] stamp(input logic [63:0] d, input int idx);
    logic [63:0] r;
    r = d;
    r[59:56] = 4'(idx);
    return r;
  endfunction

  // Random-test storage and reference model state.
  logic [63:0] src_d [NA][$];
  logic        src_l [NA][$];
  logic [63:0] exp_d [$];
  logic        exp_l [$];
  int          left_pk [NA];
  int          rd [NA];
  int          wr [NA];
  logic        at_hdr [NA];
  int          total_pk, last_c, c, len, oi;
  logic        first_b, lb, prev_stall, prev_l;
  logic [63:0] d, prev_d;

  logic [63:0] bd [$];
  logic        bl [$];
  logic        bexp_v [$];
  logic [63:0] bexp_d [$];
  logic        bexp_l [$];
  int          bwr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_ivalid = '0; a_idata = '0; a_ilast = '0; a_oready = 1'b1;
    b_ivalid = '0; b_idata = '0; b_ilast = '0; b_oready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_ovalid", a_ovalid, 0);
    chk("rst_a_odata", a_odata, 0);
    chk("rst_a_olast", a_olast, 0);
    chk("rst_a_iready", a_iready, 0);
    chk("rst_b_ovalid", b_ovalid, 0);
    @(negedge clk); rst = 1'b0;

    // Three-beat packet on input 2 with route stamp.
    @(negedge clk);
    a_ivalid[2] = 1'b1; a_idata[2*DW +: DW] = 64'h0000_0000_8000_1000; a_ilast[2] = 1'b0;
    #1; chk("t1_idle_ready", a_iready, 0); chk("t1_ovalid_c0", a_ovalid, 0);
    @(negedge clk); #1;
    chk("t1_grant_ready", a_iready, 4'b0100); chk("t1_ovalid_c1", a_ovalid, 0);
    @(negedge clk);
    a_idata[2*DW +: DW] = 64'h1111_2222_3333_4444;
    #1; chk("t1_hdr_valid", a_ovalid, 1); chk("t1_hdr_data", a_odata, 64'h0200_0000_8000_1000);
    chk("t1_hdr_last", a_olast, 0);
    @(negedge clk);
    a_idata[2*DW +: DW] = 64'h5555_6666_7777_8888; a_ilast[2] = 1'b1;
    #1; chk("t1_b2_data", a_odata, 64'h1111_2222_3333_4444); chk("t1_b2_last", a_olast, 0);
    @(negedge clk);
    a_ivalid[2] = 1'b0; a_ilast[2] = 1'b0;
    #1; chk("t1_b3_data", a_odata, 64'h5555_6666_7777_8888); chk("t1_b3_last", a_olast, 1);
    chk("t1_b3_valid", a_ovalid, 1); chk("t1_back_idle", a_iready, 0);
    @(negedge clk); #1; chk("t1_drained", a_ovalid, 0);

    // All inputs hold single-beat packets: rotation 0,1,2,3,0,1, one packet per two cycles.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NA; i++) a_idata[i*DW +: DW] = 64'h00A0 + 64'(i);
    a_ivalid = 4'hF; a_ilast = 4'hF;
    for (int k = 0; k <= 12; k++) begin
      #1;
      if (k >= 2 && (k % 2) == 0) begin
        chk("t2_valid", a_ovalid, 1);
        chk("t2_order", a_odata, stamp(64'h00A0 + 64'(((k - 2) / 2) % NA), ((k - 2) / 2) % NA));
      end else begin
        chk("t2_bubble", a_ovalid, 0);
      end
      if (k == 12) begin
        a_ivalid = '0; a_ilast = '0;
      end
      @(negedge clk);
    end

    // Granted input 3 stalls mid-packet; input 0 must wait.
    a_ivalid[3] = 1'b1; a_idata[3*DW +: DW] = 64'h00C0; a_ilast[3] = 1'b0;
    @(negedge clk); #1; chk("t4_grant3", a_iready, 4'b1000);
    @(negedge clk);
    a_ivalid[3] = 1'b0;
    a_ivalid[0] = 1'b1; a_idata[0 +: DW] = 64'h00A0; a_ilast[0] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      if (j == 0) chk("t4_hdr", a_odata, stamp(64'h00C0, 3));
      chk("t4_hold_grant", a_iready, 4'b1000);
      @(negedge clk);
    end
    a_ivalid[3] = 1'b1; a_idata[3*DW +: DW] = 64'h00C1; a_ilast[3] = 1'b1;
    #1; chk("t4_resume", a_iready, 4'b1000);
    @(negedge clk);
    a_ivalid[3] = 1'b0; a_ilast[3] = 1'b0;
    #1; chk("t4_tail_data", a_odata, 64'h00C1); chk("t4_tail_last", a_olast, 1);
    @(negedge clk); #1; chk("t4_next_is_0", a_iready, 4'b0001);
    @(negedge clk);
    a_ivalid = '0; a_ilast = '0;
    #1; chk("t4_in0_data", a_odata, 64'h00A0);

    // Asynchronous reset during beat 2 of a packet on input 1.
    @(negedge clk);
    a_ivalid[1] = 1'b1; a_idata[1*DW +: DW] = 64'h00B0; a_ilast[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); a_idata[1*DW +: DW] = 64'h00B1;
    @(negedge clk); a_idata[1*DW +: DW] = 64'h00B2;
    #1; chk("t5_b2_out", a_odata, 64'h00B1);
    rst = 1'b1;
    #1; chk("t5_rst_ovalid", a_ovalid, 0); chk("t5_rst_iready", a_iready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NA; i++) a_idata[i*DW +: DW] = 64'h00D0 + 64'(i);
    a_ivalid = 4'hF; a_ilast = 4'hF;
    @(negedge clk); #1; chk("t5_first_is_0", a_iready, 4'b0001);
    @(negedge clk);
    a_ivalid = '0; a_ilast = '0;
    #1; chk("t5_first_data", a_odata, 64'h00D0);

    // Randomized packets with gaps and backpressure against a packet-level model.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total_pk = 0;
    for (int i = 0; i < NA; i++) begin
      left_pk[i] = int'($urandom_range(2, 4));
      total_pk += left_pk[i];
      rd[i] = 0; wr[i] = 0; at_hdr[i] = 1'b1;
      for (int p = 0; p < left_pk[i]; p++) begin
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          src_d[i].push_back({$urandom, $urandom});
          src_l[i].push_back(b == len - 1);
        end
      end
    end
    last_c = NA - 1;
    while (total_pk > 0) begin
      c = -1;
      for (int off = 1; off <= NA; off++)
        if (c < 0 && left_pk[(last_c + off) % NA] > 0) c = (last_c + off) % NA;
      first_b = 1'b1;
      do begin
        d = src_d[c][rd[c]];
        if (first_b) d = stamp(d, c);
        lb = src_l[c][rd[c]];
        exp_d.push_back(d); exp_l.push_back(lb);
        rd[c]++; first_b = 1'b0;
      end while (!lb);
      left_pk[c]--; total_pk--; last_c = c;
    end
    oi = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    for (int cyc = 0; cyc < 4000 && oi < exp_d.size(); cyc++) begin
      @(negedge clk);
      a_oready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NA; i++) begin
        if (wr[i] < src_d[i].size()) begin
          a_ivalid[i] = at_hdr[i] || ($urandom_range(0, 2) != 0);
          a_idata[i*DW +: DW] = src_d[i][wr[i]];
          a_ilast[i] = src_l[i][wr[i]];
        end else begin
          a_ivalid[i] = 1'b0;
          a_idata[i*DW +: DW] = {$urandom, $urandom};
          a_ilast[i] = 1'($urandom_range(0, 1));
        end
      end
      #1;
      if (prev_stall) begin
        chk("rnd_hold_valid", a_ovalid, 1);
        chk("rnd_hold_data", a_odata, prev_d);
        chk("rnd_hold_last", a_olast, prev_l);
      end
      chk("rnd_ready_onehot", ($countones(a_iready) <= 1), 1);
      if (a_ovalid && a_oready) begin
        chk("rnd_data", a_odata, exp_d[oi]);
        chk("rnd_last", a_olast, exp_l[oi]);
        oi++;
      end
      for (int i = 0; i < NA; i++)
        if (a_ivalid[i] && a_iready[i]) begin
          at_hdr[i] = src_l[i][wr[i]];
          wr[i]++;
        end
      prev_stall = a_ovalid && !a_oready;
      prev_d = a_odata; prev_l = a_olast;
    end
    chk("rnd_all_beats_out", oi, exp_d.size());
    @(negedge clk);
    a_ivalid = '0; a_ilast = '0; a_oready = 1'b1;

    // Single-input passthrough: lengths 1, 2, 7 with one bubble between packets.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bexp_v.push_back(1'b0); bexp_d.push_back('0); bexp_l.push_back(1'b0);
    bexp_v.push_back(1'b0); bexp_d.push_back('0); bexp_l.push_back(1'b0);
    for (int p = 0; p < 3; p++) begin
      len = (p == 0) ? 1 : (p == 1) ? 2 : 7;
      for (int b = 0; b < len; b++) begin
        d = {$urandom, $urandom};
        bd.push_back(d); bl.push_back(b == len - 1);
        bexp_v.push_back(1'b1); bexp_d.push_back(d); bexp_l.push_back(b == len - 1);
      end
      bexp_v.push_back(1'b0); bexp_d.push_back('0); bexp_l.push_back(1'b0);
    end
    bwr = 0;
    for (int k = 0; k < bexp_v.size(); k++) begin
      @(negedge clk);
      if (bwr < bd.size()) begin
        b_ivalid = 1'b1; b_idata = bd[bwr]; b_ilast = bl[bwr];
      end else begin
        b_ivalid = 1'b0; b_idata = '0; b_ilast = 1'b0;
      end
      #1;
      chk("b_valid", b_ovalid, bexp_v[k]);
      if (bexp_v[k]) begin
        chk("b_data", b_odata, bexp_d[k]);
        chk("b_last", b_olast, bexp_l[k]);
      end
      if (b_ivalid[0] && b_iready[0]) bwr++;
    end
    chk("b_all_accepted", bwr, bd.size());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
